mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-stage consumer of the Execute→Memory pipeline register. It takes the M-stage control bundle (RegWriteM, ResultSrcM, MemWriteM) and datapath values, runs loads and stores over a req/ack data-memory bus, and stalls the pipeline while an access is outstanding. It also holds the Memory→Writeback pipeline register, including load byte/half extraction.

Parameters:
DATA_WIDTH, 32, address and data width
TIMEOUT_CYCLES, 255, maximum ack wait before abort; counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
RegWriteM  in  1  M-stage register write enable
ResultSrcM  in  2  M-stage result select; 2'b01 = load
MemWriteM  in  1  M-stage store
funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
ALUResultM  in  32  effective address / ALU result
WriteDataM  in  32  store data
RdM  in  5  destination register
PCPlus4M  in  32  link value
StallM  out  1  freezes F/D/E/M registers while high
mem_req  out  1  bus request, held until ack
mem_we  out  1  1 = store
mem_addr  out  32  word-aligned address {ALUResultM[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  access complete; rdata valid this cycle for loads
mem_rdata  in  32  read word
RegWriteW, ResultSrcW[2], ALUResultW[32], ReadDataW[32], RdW[5], PCPlus4W[32]  out  Writeback register
BusErr  out  1  sticky timeout flag

Behaviour:
- memop = MemWriteM | (ResultSrcM==2'b01).
- Reset (async): state IDLE, all W outputs 0, mem_req 0, timeout counter 0, BusErr 0. Asserting reset mid-access drops mem_req immediately. A late ack after reset is ignored.
- FSM has two states, IDLE and WAIT.
  - IDLE, memop=0: StallM=0. The W register loads the M bundle on the next edge (1-cycle latency). ReadDataW is 0.
  - IDLE, memop=1: StallM=1 combinationally. Go to WAIT. The W register loads a bubble (RegWriteW=0, all other W fields 0).
  - WAIT: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are taken from the held M inputs and stay stable until ack.
  - WAIT with mem_ack=0: StallM=1, counter increments, bubble into W.
  - WAIT with mem_ack=1: StallM=0 in that same cycle. On that edge the W register loads the M bundle, with ReadDataW set to the extracted load data (0 for stores). Return to IDLE and clear the counter.
- Minimum memop latency is 2 cycles (ack in the first WAIT cycle).
- Back-to-back memops: after returning to IDLE, the next memop instruction enters WAIT on the following edge. There is no idle gap beyond the IDLE detect cycle.
- Timeout: when the counter reaches TIMEOUT_CYCLES in WAIT without ack:
  - drop mem_req and set BusErr (sticky until reset);
  - load a bubble into W, deassert StallM and return to IDLE. The instruction is dropped.
- Store byte enables (a = ALUResultM[1:0]):
  - SB: be = 4'b0001 << a, wdata = byte replicated ×4.
  - SH: be = a[1] ? 4'b1100 : 4'b0011, wdata = half replicated ×2.
  - SW: be = 4'b1111.
  - Loads drive mem_be = 4'b1111.
- Load extraction: select the byte by a, or the half by a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misaligned addresses (H with a[0]=1, W with a≠0) are issued as if the low bits were masked, unless the optional feature below is compiled in.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output MisalignM (1 bit). A misaligned memop in IDLE does not enter WAIT and never asserts mem_req. MisalignM pulses high for that cycle, StallM stays 0, and the W register loads a bubble.
- Undefined: the port is absent and low bits are masked as above.

Test Plan:
- Non-memop: ALU op with RegWriteM=1, RdM=5, ALUResultM=0x10 → next edge RegWriteW=1, RdW=5, ALUResultW=0x10; StallM never high.
- LW, addr 0x100, ack 3 cycles after mem_req rises, rdata=0xDEADBEEF:
  - mem_addr=0x100 and mem_be=1111 held stable while waiting;
  - StallM high 4 cycles;
  - ReadDataW=0xDEADBEEF, RegWriteW=1 after the ack edge.
- LB addr 0x103, rdata=0x80FFFFFF → ReadDataW=0xFFFFFF80. LBU, same inputs → ReadDataW=0x00000080.
- SH addr 0x202, WriteDataM=0x1234ABCD, immediate ack → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, RegWriteW=0.
- Timeout: TIMEOUT_CYCLES=4, no ack → mem_req drops after 4 WAIT cycles, BusErr=1 and remains 1, StallM=0, W holds a bubble. A reset assertion mid-WAIT → mem_req=0 and BusErr=0 immediately.
- With MISALIGN_TRAP_EN: LW addr 0x101 → MisalignM pulses 1, mem_req stays 0, RegWriteW=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives a req/ack data bus for loads and stores and holds the M->W register.
// Optional MISALIGN_TRAP_EN adds MisalignM and suppresses misaligned accesses instead of masking them.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    RegWriteM,
  input  logic [1:0]              ResultSrcM,
  input  logic                    MemWriteM,
  input  logic [2:0]              funct3M,
  input  logic [DATA_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  input  logic [4:0]              RdM,
  input  logic [DATA_WIDTH-1:0]   PCPlus4M,
  output logic                    StallM,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    RegWriteW,
  output logic [1:0]              ResultSrcW,
  output logic [DATA_WIDTH-1:0]   ALUResultW,
  output logic [DATA_WIDTH-1:0]   ReadDataW,
  output logic [4:0]              RdW,
  output logic [DATA_WIDTH-1:0]   PCPlus4W,
  output logic                    BusErr
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                    MisalignM
`endif
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BeW  = DATA_WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            bus_err_q, bus_err_d;

  logic                  reg_write_q, reg_write_d;
  logic [1:0]            result_src_q, result_src_d;
  logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

  logic                  is_load, memop, in_wait, load_bundle;
  logic [1:0]            a;
  logic [BeW-1:0]        st_be;
  logic [DATA_WIDTH-1:0] st_wdata, ld_ext, load_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign a       = ALUResultM[1:0];
  assign is_load = (ResultSrcM == 2'b01);
  assign memop   = MemWriteM | is_load;
  assign in_wait = (state_q == StWait);
  assign cnt_inc = cnt_q + CntW'(1);

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((funct3M[1:0] == 2'b01) & a[0]) | (funct3M[1] & (a != 2'b00));
`endif

  // Store lane steering; misaligned halves/words simply ignore the low address bits.
  always_comb begin
    st_be    = '1;
    st_wdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        st_be    = BeW'(1) << a;
        st_wdata = {(DATA_WIDTH/8){WriteDataM[7:0]}};
      end
      2'b01: begin
        st_be    = a[1] ? BeW'(4'b1100) : BeW'(4'b0011);
        st_wdata = {(DATA_WIDTH/16){WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{a, 3'b000} +: 8];
    ld_half = mem_rdata[{a[1], 4'b0000} +: 16];
    case (funct3M)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  assign mem_we    = in_wait & MemWriteM;
  assign mem_addr  = in_wait ? {ALUResultM[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_be    = in_wait ? (MemWriteM ? st_be : '1) : '0;
  assign mem_wdata = (in_wait & MemWriteM) ? st_wdata : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
    StallM      = 1'b0;
    mem_req     = 1'b0;
    load_bundle = 1'b0;
    load_data   = '0;
`ifdef MISALIGN_TRAP_EN
    MisalignM   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!memop) begin
          load_bundle = 1'b1;
`ifdef MISALIGN_TRAP_EN
        end else if (misalign) begin
          MisalignM = 1'b1;
`endif
        end else begin
          StallM  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          load_bundle = 1'b1;
          load_data   = is_load ? ld_ext : '0;
          state_d     = StIdle;
          cnt_d       = '0;
        end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
          // Abandon the access: release the pipeline and drop the instruction.
          bus_err_d = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
        end else begin
          StallM = 1'b1;
          cnt_d  = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = '0;
    alu_result_d = '0;
    read_data_d  = '0;
    rd_d         = '0;
    pc_plus4_d   = '0;
    if (load_bundle) begin
      reg_write_d  = RegWriteM;
      result_src_d = ResultSrcM;
      alu_result_d = ALUResultM;
      read_data_d  = load_data;
      rd_d         = RdM;
      pc_plus4_d   = PCPlus4M;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign ALUResultW = alu_result_q;
  assign ReadDataW  = read_data_q;
  assign RdW        = rd_q;
  assign PCPlus4W   = pc_plus4_q;
  assign BusErr     = bus_err_q;

endmodule
